// File: rtl/message_receiver_if.sv
// Receiver-side bus: serial input, enable, status/byte outputs and the rd_en/rd_data readout handshake.
// master = the receiver itself, slave = the consumer (message/echo logic).
interface message_receiver_if;
  logic       SW;
  logic       rxd;
  logic [7:0] word;
  logic [9:0] counter;
  logic       recieve_ready;
  logic       message_ready;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       frame_error;
  logic       overrun;

  modport master (
    input  SW, rxd, rd_en,
    output word, counter, recieve_ready, message_ready, rd_data, frame_error, overrun
  );

  modport slave (
    output SW, rxd, rd_en,
    input  word, counter, recieve_ready, message_ready, rd_data, frame_error, overrun
  );
endinterface

// File: rtl/message_receiver.sv
// UART 8N1 receiver (8E1 when RX_PARITY_EN is defined) filling a line buffer up to a terminator; byte result 1 cycle after stop sample.
// rd_data valid the cycle after rd_en; bytes arriving while a message is held are dropped with an overrun pulse.
module message_receiver #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         DEPTH        = 32,
  parameter logic [7:0] TERMINATOR   = 8'h0D
) (
  input logic                clk,
  input logic                rst,
  message_receiver_if.master bus
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam int             AW        = $clog2(DEPTH);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [9:0]     DEPTH_C   = 10'(DEPTH);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick;
  logic          stop_tick;
  logic          frame_bad;
  logic          store;
  logic [7:0]    mem [DEPTH];
  logic [9:0]    rd_ptr, count;
  logic [7:0]    word_q, rd_data_q;
  logic          rr_q, mr_q, fe_q, ov_q;
  logic          par_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      IDLE:  if (rxd_prev && !rxd_sync) state_nxt = START;
      START: if (clk_cnt == HALF_LAST) begin
        tick      = 1'b1;
        state_nxt = rxd_sync ? IDLE : DATA;
      end
      DATA:  if (clk_cnt == BIT_LAST) begin
        tick = 1'b1;
`ifdef RX_PARITY_EN
        if (bit_idx == 3'd7) state_nxt = PARITY;
`else
        if (bit_idx == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef RX_PARITY_EN
      PARITY: if (clk_cnt == BIT_LAST) begin
        tick      = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP:  if (clk_cnt == BIT_LAST) begin
        tick      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping the enable abandons any partial frame silently.
    if (!bus.SW) state_nxt = IDLE;
  end

  assign stop_tick = tick && (state == STOP) && bus.SW;
`ifdef RX_PARITY_EN
  assign frame_bad = !rxd_sync || par_err;
`else
  assign frame_bad = !rxd_sync;
`endif
  assign store = stop_tick && !frame_bad && !mr_q && (shift != TERMINATOR);

  // The fill count doubles as the write pointer: no concurrent fill and drain.
  always_ff @(posedge clk) begin
    if (store) mem[count[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_err   <= 1'b0;
      rd_ptr    <= '0;
      count     <= '0;
      word_q    <= '0;
      rd_data_q <= '0;
      rr_q      <= 1'b0;
      mr_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rxd_meta <= bus.rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rr_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      clk_cnt  <= (state == IDLE || tick || !bus.SW) ? '0 : clk_cnt + 1'b1;

      if (tick && state == START) begin
        bit_idx <= '0;
        par_err <= 1'b0;
      end
      if (tick && state == DATA) begin
        shift   <= {rxd_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef RX_PARITY_EN
      if (tick && state == PARITY) par_err <= ^{rxd_sync, shift};
`endif

      if (stop_tick) begin
        if (frame_bad) begin
          fe_q <= 1'b1;
        end else begin
          word_q <= shift;
          rr_q   <= 1'b1;
          if (mr_q) begin
            ov_q <= 1'b1;
          end else if (shift == TERMINATOR) begin
            if (count != 10'd0) mr_q <= 1'b1;
          end else begin
            count <= count + 10'd1;
            if (count == DEPTH_C - 10'd1) mr_q <= 1'b1;
          end
        end
      end

      if (bus.rd_en && mr_q) begin
        rd_data_q <= mem[rd_ptr[AW-1:0]];
        if (rd_ptr == count - 10'd1) begin
          mr_q   <= 1'b0;
          count  <= '0;
          rd_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + 10'd1;
        end
      end
    end
  end

  assign bus.word          = word_q;
  assign bus.counter       = count;
  assign bus.recieve_ready = rr_q;
  assign bus.message_ready = mr_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.frame_error   = fe_q;
  assign bus.overrun       = ov_q;
endmodule

// File: tb/tb_message_receiver.sv
// Directed bench for message_receiver: serial frames driven on rxd, pulses counted on the falling clock edge.
module tb_message_receiver;
  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  message_receiver_if bus();

  message_receiver #(.CLKS_PER_BIT(CPB), .DEPTH(32), .TERMINATOR(8'h0D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rr_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int rr0 = 0, fe0 = 0, ov0 = 0;

  always @(negedge clk) begin
    if (bus.recieve_ready) rr_cnt++;
    if (bus.frame_error)   fe_cnt++;
    if (bus.overrun)       ov_cnt++;
  end

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    rr0 = rr_cnt;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
  endtask

  // start + data (+ parity) + stop, then two idle bit times
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
    logic [10:0] f;
    f = {stop_b, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < NBITS; i++) begin
      bus.rxd = f[i];
      idle(CPB);
    end
    bus.rxd = stop_b;
    idle(CPB);
    bus.rxd = 1'b1;
    idle(2 * CPB);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SW    = 1'b1;
    bus.rxd   = 1'b1;
    bus.rd_en = 1'b0;
    rst       = 1'b1;
    idle(2);
    chk("rst_word", 10'(bus.word), 10'h000);
    chk("rst_counter", bus.counter, 10'd0);
    chk("rst_msg_ready", 10'(bus.message_ready), 10'd0);
    chk("rst_rd_data", 10'(bus.rd_data), 10'h000);
    chk("rst_pulses", 10'({bus.recieve_ready, bus.frame_error, bus.overrun}), 10'd0);
    rst = 1'b0;
    idle(CPB);

    // "Hi" + CR, then drain
    mark();
    send(8'h48, 1'b1, 1'b0);
    send(8'h69, 1'b1, 1'b0);
    send(8'h0D, 1'b1, 1'b0);
    chk("hi_rr_pulses", 10'(rr_cnt - rr0), 10'd3);
    chk("hi_counter", bus.counter, 10'd2);
    chk("hi_msg_ready", 10'(bus.message_ready), 10'd1);
    chk("hi_word", 10'(bus.word), 10'h00D);
    pop();
    chk("pop1_data", 10'(bus.rd_data), 10'h048);
    chk("pop1_msg_ready", 10'(bus.message_ready), 10'd1);
    pop();
    chk("pop2_data", 10'(bus.rd_data), 10'h069);
    chk("pop2_msg_ready", 10'(bus.message_ready), 10'd0);
    chk("pop2_counter", bus.counter, 10'd0);
    pop();
    chk("pop_idle_hold", 10'(bus.rd_data), 10'h069);

    // short low glitch is rejected, next real frame still lands
    mark();
    bus.rxd = 1'b0;
    idle(4);
    bus.rxd = 1'b1;
    idle(3 * CPB);
    chk("glitch_rr", 10'(rr_cnt - rr0), 10'd0);
    chk("glitch_fe", 10'(fe_cnt - fe0), 10'd0);
    send(8'h5A, 1'b1, 1'b0);
    chk("after_glitch_word", 10'(bus.word), 10'h05A);
    chk("after_glitch_counter", bus.counter, 10'd1);

    // bad stop bit
    mark();
    send(8'h55, 1'b0, 1'b0);
    chk("fe_pulse", 10'(fe_cnt - fe0), 10'd1);
    chk("fe_no_rr", 10'(rr_cnt - rr0), 10'd0);
    chk("fe_counter", bus.counter, 10'd1);
    chk("fe_word", 10'(bus.word), 10'h05A);
    send(8'h0D, 1'b1, 1'b0);
    chk("cr_msg_ready", 10'(bus.message_ready), 10'd1);
    pop();
    chk("pop_5a", 10'(bus.rd_data), 10'h05A);
    chk("pop_5a_counter", bus.counter, 10'd0);

    // fill to DEPTH without terminator, then overrun
    for (int i = 0; i < 31; i++) send(8'h41, 1'b1, 1'b0);
    chk("fill31_counter", bus.counter, 10'd31);
    chk("fill31_msg_ready", 10'(bus.message_ready), 10'd0);
    send(8'h41, 1'b1, 1'b0);
    chk("fill32_counter", bus.counter, 10'd32);
    chk("fill32_msg_ready", 10'(bus.message_ready), 10'd1);
    mark();
    send(8'h42, 1'b1, 1'b0);
    chk("ovr_pulse", 10'(ov_cnt - ov0), 10'd1);
    chk("ovr_rr", 10'(rr_cnt - rr0), 10'd1);
    chk("ovr_counter", bus.counter, 10'd32);
    chk("ovr_word", 10'(bus.word), 10'h042);
    for (int i = 0; i < 32; i++) pop();
    chk("drain_data", 10'(bus.rd_data), 10'h041);
    chk("drain_counter", bus.counter, 10'd0);
    chk("drain_msg_ready", 10'(bus.message_ready), 10'd0);
    mark();
    send(8'h0D, 1'b1, 1'b0);
    chk("lone_cr_rr", 10'(rr_cnt - rr0), 10'd1);
    chk("lone_cr_msg_ready", 10'(bus.message_ready), 10'd0);
    chk("lone_cr_counter", bus.counter, 10'd0);

    // enable dropped mid-frame
    send(8'h42, 1'b1, 1'b0);
    mark();
    bus.rxd = 1'b0;
    idle(3 * CPB);
    bus.SW = 1'b0;
    idle(CPB);
    bus.rxd = 1'b1;
    idle(8 * CPB);
    bus.SW = 1'b1;
    idle(2 * CPB);
    chk("sw_off_pulses", 10'((rr_cnt - rr0) + (fe_cnt - fe0) + (ov_cnt - ov0)), 10'd0);
    chk("sw_off_counter", bus.counter, 10'd1);
    send(8'h0D, 1'b1, 1'b0);
    bus.SW = 1'b0;
    pop();
    chk("sw_off_pop", 10'(bus.rd_data), 10'h042);
    chk("sw_off_msg_ready", 10'(bus.message_ready), 10'd0);
    bus.SW = 1'b1;
    idle(CPB);

`ifdef RX_PARITY_EN
    mark();
    send(8'h01, 1'b1, 1'b1);
    chk("par_fe", 10'(fe_cnt - fe0), 10'd1);
    chk("par_no_rr", 10'(rr_cnt - rr0), 10'd0);
    chk("par_counter", bus.counter, 10'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
